// File: rtl/stream_lookahead_buffer.sv
// Circular character buffer presenting a PEEK-wide lookahead window with multi-char consume.
// Optional line/column tracking of window slot 0 is enabled by defining STREAM_POS_TRACK_EN.
module stream_lookahead_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PEEK   = 4,
  parameter int POS_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [PEEK*DATA_W-1:0]       peek_data,
  output logic [PEEK-1:0]              peek_valid,
  input  logic                         consume,
  input  logic [$clog2(PEEK+1)-1:0]    consume_n,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         eof,
`ifdef STREAM_POS_TRACK_EN
  output logic [POS_W-1:0]             line,
  output logic [POS_W-1:0]             col,
`endif
  output logic                         err_ovc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CN_W  = $clog2(PEEK+1);
  localparam int EW    = (CNT_W > CN_W) ? CNT_W : CN_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_seen_q, last_seen_d;
  logic              err_q, err_d;
  logic              push;
  logic [CNT_W-1:0]  eff;
  logic [EW-1:0]     req_w, cnt_w;

  assign in_ready = (count_q < CNT_W'(DEPTH)) && !last_seen_q;
  assign push     = in_valid && in_ready;
  assign count    = count_q;
  assign eof      = last_seen_q && (count_q == '0);
  assign err_ovc  = err_q;

  // Over-consume is clipped to what is held; the request is flagged instead of underflowing.
  always_comb begin
    req_w = EW'(consume_n);
    cnt_w = EW'(count_q);
    eff   = '0;
    err_d = 1'b0;
    if (consume) begin
      if (req_w > cnt_w) begin
        eff   = count_q;
        err_d = 1'b1;
      end else begin
        eff   = CNT_W'(req_w);
      end
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q + PTR_W'(eff);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    count_d     = count_q + CNT_W'(push) - eff;
    last_seen_d = last_seen_q || (push && in_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (flush) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    peek_data  = '0;
    peek_valid = '0;
    for (int k = 0; k < PEEK; k++) begin
      peek_data[k*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PTR_W'(k)];
      peek_valid[k]                 = CNT_W'(k) < count_q;
    end
  end

`ifdef STREAM_POS_TRACK_EN
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [POS_W-1:0] line_q, line_d;
  logic [POS_W-1:0] col_q, col_d;

  // Walk every consumed char oldest first; consume_n may reach beyond the visible window.
  always_comb begin
    line_d = line_q;
    col_d  = col_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < eff) begin
        if (mem_q[rd_ptr_q + PTR_W'(k)] == DATA_W'('h0A)) begin
          if (line_d != POS_MAX) line_d = line_d + POS_W'(1);
          col_d = POS_W'(1);
        end else if (col_d != POS_MAX) begin
          col_d = col_d + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= POS_W'(1);
      col_q  <= POS_W'(1);
    end else if (flush) begin
      line_q <= POS_W'(1);
      col_q  <= POS_W'(1);
    end else begin
      line_q <= line_d;
      col_q  <= col_d;
    end
  end

  assign line = line_q;
  assign col  = col_q;
`endif

endmodule

// File: tb/tb_stream_lookahead_buffer.sv
// Directed bench for stream_lookahead_buffer (default parameters); exercises position
// tracking as well when STREAM_POS_TRACK_EN is defined.
module tb_stream_lookahead_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, consume, flush;
  logic [7:0]  in_data;
  logic [2:0]  consume_n;
  logic        in_ready, eof, err_ovc;
  logic [31:0] peek_data;
  logic [3:0]  peek_valid;
  logic [3:0]  count;
`ifdef STREAM_POS_TRACK_EN
  logic [15:0] line, col;
`endif

  int total = 0;
  int bad   = 0;

  stream_lookahead_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .peek_data(peek_data), .peek_valid(peek_valid),
    .consume(consume), .consume_n(consume_n), .flush(flush),
    .count(count), .eof(eof),
`ifdef STREAM_POS_TRACK_EN
    .line(line), .col(col),
`endif
    .err_ovc(err_ovc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_last = 0; consume = 0; consume_n = 0; flush = 0; in_data = 0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    step();
    flush = 0;
  endtask

  function automatic logic [7:0] slot(input int k);
    return peek_data[k*8 +: 8];
  endfunction

  logic [7:0] q[$];
  int sent, pre, n, eff, cyc;
  bit exp_rdy, exp_push;

  initial begin
    idle();
    rst_n = 0;
    #12 rst_n = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_pv", peek_valid, 0);
    chk("rst_eof", eof, 0);
    chk("rst_err", err_ovc, 0);
    chk("rst_rdy", in_ready, 1);
`ifdef STREAM_POS_TRACK_EN
    chk("rst_line", line, 1);
    chk("rst_col", col, 1);
`endif

    // 1: three pushes, no consume; no same-cycle bypass into the window
    in_valid = 1; in_data = 8'h7B;
    #1 chk("t1_nobypass", peek_valid, 0);
    step();
    in_data = 8'h22; step();
    in_data = 8'h61; step();
    in_valid = 0;
    chk("t1_count", count, 3);
    chk("t1_pv", peek_valid, 4'b0111);
    chk("t1_s0", slot(0), 8'h7B);
    chk("t1_s2", slot(2), 8'h61);
    chk("t1_rdy", in_ready, 1);

    // flush beats a simultaneous push
    in_valid = 1; in_data = 8'h55; flush = 1;
    step();
    idle();
    chk("fl_count", count, 0);
    chk("fl_pv", peek_valid, 0);

    // 2: fill to DEPTH, then consume while upstream still offers data
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = 8'(i);
      step();
    end
    in_valid = 0;
    chk("t2_full", count, 8);
    chk("t2_rdy0", in_ready, 0);
    in_valid = 1; in_data = 8'hAA; consume = 1; consume_n = 2;
    #1 chk("t2_rdy_consume", in_ready, 0);
    step();
    idle();
    chk("t2_count", count, 6);
    chk("t2_s0", slot(0), 8'h02);
    chk("t2_s3", slot(3), 8'h05);
    chk("t2_rdy1", in_ready, 1);

    // 3: 20 chars through with random consume sizes, checked against a queue model
    do_flush();
    q.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 20 || q.size() > 0) && cyc < 300) begin
      in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      in_data   = 8'h40 + 8'(sent);
      consume   = 1;
      n         = $urandom_range(0, 4);
      consume_n = 3'(n);
      pre       = q.size();
      exp_rdy   = pre < 8;
      exp_push  = in_valid && exp_rdy;
      #1 chk("t3_rdy", in_ready, 32'(exp_rdy));
      step();
      eff = (n > pre) ? pre : n;
      for (int i = 0; i < eff; i++) void'(q.pop_front());
      if (exp_push) begin
        q.push_back(in_data);
        sent++;
      end
      chk("t3_err", err_ovc, 32'(n > pre));
      chk("t3_count", count, q.size());
      for (int k = 0; k < 4; k++)
        if (k < q.size()) chk("t3_slot", slot(k), q[k]);
      cyc++;
    end
    idle();
    chk("t3_sent", sent, 20);
    chk("t3_drained", count, 0);

    // 4: over-consume clips to count and pulses err_ovc for one cycle
    do_flush();
    in_valid = 1; in_data = 8'h10; step();
    in_data = 8'h11; step();
    in_valid = 0;
    consume = 1; consume_n = 3;
    step();
    idle();
    chk("t4_count", count, 0);
    chk("t4_err", err_ovc, 1);
    chk("t4_pv", peek_valid, 0);
    step();
    chk("t4_err_drop", err_ovc, 0);
    chk("t4_nounder", count, 0);

    // 5: last char, eof, input blocked, then flush
    do_flush();
    in_valid = 1; in_data = 8'h31; in_last = 1;
    step();
    idle();
    chk("t5_rdy_last", in_ready, 0);
    chk("t5_eof_early", eof, 0);
    consume = 1; consume_n = 1;
    step();
    idle();
    chk("t5_eof", eof, 1);
    chk("t5_rdy", in_ready, 0);
    in_valid = 1; in_data = 8'h32;
    step();
    idle();
    chk("t5_blocked", count, 0);
    chk("t5_eof_hold", eof, 1);
    do_flush();
    chk("t5_fl_eof", eof, 0);
    chk("t5_fl_rdy", in_ready, 1);
    chk("t5_fl_count", count, 0);

`ifdef STREAM_POS_TRACK_EN
    // 6: "a\nbc" consumed in one go
    in_valid = 1; in_data = 8'h61; step();
    in_data = 8'h0A; step();
    in_data = 8'h62; step();
    in_data = 8'h63; step();
    idle();
    consume = 1; consume_n = 4;
    step();
    idle();
    chk("t6_line", line, 2);
    chk("t6_col", col, 3);
    do_flush();
    chk("t6_fl_line", line, 1);
    chk("t6_fl_col", col, 1);
`endif

    // asynchronous reset mid-stream clears without waiting for a clock edge
    in_valid = 1; in_data = 8'h77; step(); step();
    idle();
    chk("ar_pre", count, 2);
    #2 rst_n = 0;
    #1 chk("ar_count", count, 0);
    chk("ar_pv", peek_valid, 0);
    #3 rst_n = 1;
    step();
    chk("ar_rdy", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
